// File: rtl/signed_search.sv
// signed_search
//   Sequential binary-search engine that discovers an unknown W-bit
//   two's-complement value sitting behind an external signed magnitude
//   comparator. It presents trial values over a req/ack handshake and
//   narrows a signed [lo, hi] window from the gt/eq/lt responses.
//
// Ports
//   clk     in   rising-edge clock
//   rstn    in   asynchronous active-low reset
//   start   in   begin a search (honoured only while idle)
//   trial   out  W-bit signed trial value for the comparator
//   req     out  trial valid, held until ack
//   ack     in   comparator response valid; gt/eq/lt sampled with it
//   gt      in   hidden value > trial
//   eq      in   hidden value == trial
//   lt      in   hidden value < trial
//   busy    out  search in progress (request or gap cycle)
//   done    out  one-cycle pulse at the end of a search
//   result  out  last trial that returned eq (valid when found=1)
//   found   out  search ended on eq
//   err     out  search aborted on a non-one-hot response
//
// Build option
//   SEARCH_ONEHOT_CHECK_EN  when defined, an ack whose gt/eq/lt flags are
//                           not exactly one-hot aborts the search with
//                           err=1. When undefined, err is tied low and the
//                           flags are decoded with priority eq > gt > lt;
//                           an ack with no flag set is ignored.

module signed_search #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  output logic [W-1:0] trial,
  output logic         req,
  input  logic         ack,
  input  logic         gt,
  input  logic         eq,
  input  logic         lt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         found,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DONE
  } state_t;

  // Window bounds carry one extra bit so lo can step past the top of the
  // range (and hi past the bottom) when the responder is inconsistent.
  localparam logic signed [W:0] LO_INIT = {2'b11, {(W-1){1'b0}}};
  localparam logic signed [W:0] HI_INIT = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] ONE     = 1;

  // Floor midpoint: the sum is formed at W+2 bits so it cannot overflow,
  // then arithmetically shifted so negative sums round toward -inf.
  function automatic logic signed [W:0] midpoint(
    input logic signed [W:0] a,
    input logic signed [W:0] b
  );
    logic signed [W+1:0] s;
    s = $signed({a[W], a}) + $signed({b[W], b});
    return (W+1)'(s >>> 1);
  endfunction

  localparam logic signed [W:0] MID_INIT = midpoint(LO_INIT, HI_INIT);

  state_t            state;
  logic signed [W:0] lo;
  logic signed [W:0] hi;
  logic signed [W:0] mid;

  always_comb begin
    mid = midpoint(lo, hi);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      lo     <= LO_INIT;
      hi     <= HI_INIT;
      trial  <= '0;
      req    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      found  <= 1'b0;
`ifdef SEARCH_ONEHOT_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lo     <= LO_INIT;
            hi     <= HI_INIT;
            result <= '0;
            found  <= 1'b0;
`ifdef SEARCH_ONEHOT_CHECK_EN
            err    <= 1'b0;
`endif
            trial  <= W'(MID_INIT);
            req    <= 1'b1;
            busy   <= 1'b1;
            state  <= S_REQ;
          end
        end

        S_REQ: begin
          if (ack) begin
`ifdef SEARCH_ONEHOT_CHECK_EN
            if (!$onehot({gt, eq, lt})) begin
              err   <= 1'b1;
              found <= 1'b0;
              req   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else
`endif
            if (eq) begin
              result <= trial;
              found  <= 1'b1;
              req    <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (gt) begin
              lo    <= mid + ONE;
              req   <= 1'b0;
              state <= S_GAP;
            end else if (lt) begin
              hi    <= mid - ONE;
              req   <= 1'b0;
              state <= S_GAP;
            end
            // no flag set: response ignored, trial and req stay as they are
          end
        end

        S_GAP: begin
          // Crossed bounds can only come from an inconsistent responder.
          if (lo > hi) begin
            found <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            trial <= W'(mid);
            req   <= 1'b1;
            state <= S_REQ;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SEARCH_ONEHOT_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_signed_search.sv
module tb_signed_search;
  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rstn  = 1'b0;
  logic         start = 1'b0;
  logic         ack   = 1'b0;
  logic         gt    = 1'b0;
  logic         eq    = 1'b0;
  logic         lt    = 1'b0;
  logic [W-1:0] trial;
  logic [W-1:0] result;
  logic         req, busy, done, found, err;

  signed_search #(.W(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .trial(trial), .req(req),
    .ack(ack), .gt(gt), .eq(eq), .lt(lt), .busy(busy), .done(done),
    .result(result), .found(found), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected outcome of the search in flight
  int exp_q[$];
  bit exp_found;
  int exp_result;
  bit exp_err;
  int probe_idx = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Responder behaviour, returns {gt,eq,lt}.
  // mode 0: ideal comparator; 1: always gt; 2: gt+lt on first probe, then ideal
  function automatic logic [2:0] respond(input int mode, input int n,
                                         input int hidden, input int t);
    logic [2:0] ideal;
    ideal = (hidden > t) ? 3'b100 : (hidden == t) ? 3'b010 : 3'b001;
    case (mode)
      1:       return 3'b100;
      2:       return (n == 0) ? 3'b101 : ideal;
      default: return ideal;
    endcase
  endfunction

  // Plain integer binary search over the signed range.
  task automatic build_model(input int hidden, input int mode);
    int lo, hi, s, mid, n;
    logic [2:0] r;
    lo = -(1 << (W-1));
    hi = (1 << (W-1)) - 1;
    n = 0;
    exp_q.delete();
    exp_found = 0;
    exp_result = 0;
    exp_err = 0;
    while (n < 40) begin
      s = lo + hi;
      mid = (s >= 0) ? s / 2 : -((1 - s) / 2);
      exp_q.push_back(mid);
      r = respond(mode, n, hidden, mid);
      n++;
`ifdef SEARCH_ONEHOT_CHECK_EN
      if (!$onehot(r)) begin
        exp_err = 1;
        break;
      end
`endif
      if (r[1]) begin
        exp_found = 1;
        exp_result = mid;
        break;
      end else if (r[2]) lo = mid + 1;
      else if (r[0]) hi = mid - 1;
      if (lo > hi) break;
    end
  endtask

  // Cycle-by-cycle compare against the handshake rules and the model.
  logic         prev_req = 1'b0;
  bit           prev_gap = 0;
  bit           prev_done = 0;
  logic [W-1:0] prev_trial = '0;

  always @(negedge clk) begin
    bit accepted;
    bit gap_now;
    if (!rstn || !chk_en) begin
      prev_req  = 1'b0;
      prev_gap  = 0;
      prev_done = 0;
    end else begin
      accepted = ack && prev_req;
      gap_now  = accepted && !done;
      check("busy", int'(busy), int'(req || gap_now));
      if (accepted) check("req_drop_after_ack", int'(req), 0);
      if (prev_gap) check("single_gap", int'(req || done), 1);
      if (req && !prev_req) begin
        if (probe_idx < exp_q.size())
          check("trial", int'($signed(trial)), exp_q[probe_idx]);
        else
          check("extra_probe", probe_idx, exp_q.size());
        probe_idx++;
      end else if (req && prev_req) begin
        check("trial_stable", int'(trial), int'(prev_trial));
      end
      if (done) begin
        check("done_pulse", int'(prev_done), 0);
        check("probe_count", probe_idx, exp_q.size());
        check("probe_limit", int'(probe_idx <= W + 1), 1);
        check("found", int'(found), int'(exp_found));
        check("result", int'($signed(result)), exp_result);
        check("err", int'(err), int'(exp_err));
      end
      prev_req   = req;
      prev_gap   = gap_now;
      prev_trial = trial;
      prev_done  = done;
    end
  end

  task automatic run_search(input int hidden, input int mode, input int dly,
                            input bit poke_busy);
    int cycles, waitc, n;
    bit fin;
    logic [2:0] r;
    cycles = 0; waitc = 0; n = 0; fin = 0;
    build_model(hidden, mode);
    probe_idx = 0;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    while (!fin && cycles < 200) begin
      ack = 1'b0; {gt, eq, lt} = 3'b000; start = 1'b0;
      if (done) fin = 1;
      else if (req) begin
        if (waitc < dly) waitc++;
        else begin
          waitc = 0;
          r = respond(mode, n, hidden, int'($signed(trial)));
          n++;
          {gt, eq, lt} = r;
          ack = 1'b1;
          if (poke_busy && n == 1) start = 1'b1;
        end
      end
      if (!fin) begin
        @(negedge clk); #1;
        cycles++;
      end
    end
    if (!fin) check("search_timeout", 0, 1);
    else begin
      // start during the done cycle must be ignored
      start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      check("start_in_done_ignored", int'({req, busy}), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({trial, req, busy, done, result, found, err}), 0);
    #1 rstn = 1'b1;
    chk_en = 1;

    // pin the model to hand-computed sequences
    build_model(3, 0);
    check("model_h3_len", exp_q.size(), 2);
    check("model_h3_p0", exp_q[0], -1);
    check("model_h3_p1", exp_q[1], 3);
    build_model(-8, 0);
    check("model_hm8_len", exp_q.size(), 4);
    check("model_hm8_p2", exp_q[2], -7);
    build_model(0, 1);
    check("model_allgt_len", exp_q.size(), 5);
    check("model_allgt_last", exp_q[4], 7);
    check("model_allgt_found", int'(exp_found), 0);

    run_search(3, 0, 0, 0);
    check("h3_result_lit", int'(result), 4'b0011);
    check("h3_found_lit", int'(found), 1);

    run_search(-8, 0, 0, 0);
    check("hm8_result_lit", int'(result), 4'b1000);

    run_search(7, 0, 0, 0);
    check("h7_result_lit", int'(result), 4'b0111);

    run_search(7, 0, 3, 0);
    check("h7_slow_result_lit", int'(result), 4'b0111);

    run_search(0, 1, 0, 0);
    check("allgt_found_lit", int'(found), 0);
    check("allgt_err_lit", int'(err), 0);

    // reset during the second request of a search
    build_model(3, 0);
    probe_idx = 0;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    {gt, eq, lt} = 3'b100; ack = 1'b1;
    @(negedge clk); #1 ack = 1'b0; {gt, eq, lt} = 3'b000;
    @(negedge clk); #1;
    check("second_req_up", int'(req), 1);
    #2 rstn = 1'b0;
    #1 check("async_reset_outputs", int'({trial, req, busy, done, result, found, err}), 0);
    @(negedge clk);
    check("reset_held_outputs", int'({trial, req, busy, done, result, found, err}), 0);
    #1 rstn = 1'b1;

    run_search(-8, 0, 1, 1);
    check("after_reset_result_lit", int'(result), 4'b1000);

    run_search(3, 2, 0, 0);
`ifdef SEARCH_ONEHOT_CHECK_EN
    check("bad_flags_err_lit", int'(err), 1);
    check("bad_flags_found_lit", int'(found), 0);
`else
    check("bad_flags_found_lit", int'(found), 1);
    check("bad_flags_result_lit", int'(result), 4'b0011);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
